// File: rtl/gpr_pkg.sv
// Shared constants and helpers for the multi-port general-purpose register file.
// Scoreboard operation codes are shared so every busy-bit update reads the same way.
package gpr_pkg;

    localparam int unsigned ZERO_REG = 0;

    typedef enum logic [1:0] {
        SB_KEEP  = 2'd0,
        SB_CLEAR = 2'd1,
        SB_SET   = 2'd2
    } sb_op_e;

    function automatic int unsigned gpr_aw(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // Saturation value of a cw-bit counter; counters wider than 32 bits are not supported.
    function automatic logic [31:0] ovf_sat(input int unsigned cw);
        return (cw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << cw) - 32'd1);
    endfunction

endpackage

// File: rtl/gpr_wsel.sv
// Priority write selector: reports whether any effective write targets addr and,
// if so, the data of the highest-indexed such write.
module gpr_wsel
    import gpr_pkg::*;
#(
    parameter int W  = 32,
    parameter int AW = 5,
    parameter int NW = 2
) (
    input  logic [NW-1:0]    we,
    input  logic [NW-1:0]    wovf,
    input  logic [NW*AW-1:0] wa,
    input  logic [NW*W-1:0]  wd,
    input  logic [AW-1:0]    addr,
    output logic             hit,
    output logic [W-1:0]     data
);

    always_comb begin
        hit  = 1'b0;
        data = '0;
        // Ascending scan so the highest matching port overrides earlier ones.
        for (int k = 0; k < NW; k++) begin
            if (we[k] && !wovf[k] && (wa[k*AW +: AW] == addr)
                && (addr != AW'(ZERO_REG))) begin
                hit  = 1'b1;
                data = wd[k*W +: W];
            end
        end
    end

endmodule

// File: rtl/gpr_mp.sv
// Multi-port register file with priority writes, optional write-to-read bypass,
// overflow accounting and a per-register busy scoreboard.
module gpr_mp
    import gpr_pkg::*;
#(
    parameter int W      = 32,
    parameter int DEPTH  = 32,
    parameter int NR     = 2,
    parameter int NW     = 2,
    parameter int BYPASS = 1,
    parameter int CW     = 8,
    localparam int AW    = gpr_aw(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NR*AW-1:0] ra,
    output logic [NR*W-1:0]  rd,
    output logic [NR-1:0]    rbusy,
    input  logic [NW-1:0]    we,
    input  logic [NW*AW-1:0] wa,
    input  logic [NW*W-1:0]  wd,
    input  logic [NW-1:0]    wovf,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_a,
    input  logic             ovf_clr,
    output logic             ovf_flag,
    output logic [CW-1:0]    ovf_cnt
);

    localparam logic [CW-1:0] CNT_MAX = CW'(ovf_sat(CW));

    logic [W-1:0]     regs_reg [DEPTH];
    logic             reg_hit  [DEPTH];
    logic [W-1:0]     reg_wdata[DEPTH];
    logic [DEPTH-1:0] busy_reg;
    logic [DEPTH-1:0] busy_next;
    sb_op_e           sb_op    [DEPTH];
    logic             ovf_event;
    logic             ovf_flag_reg;
    logic [CW-1:0]    ovf_cnt_reg;

    // Per-register write decode; register 0 never sees a hit.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg_sel
        gpr_wsel #(
            .W  (W),
            .AW (AW),
            .NW (NW)
        ) u_wsel (
            .we   (we),
            .wovf (wovf),
            .wa   (wa),
            .wd   (wd),
            .addr (AW'(gi)),
            .hit  (reg_hit[gi]),
            .data (reg_wdata[gi])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_reg[r] <= '0;
            end
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                if (reg_hit[r]) begin
                    regs_reg[r] <= reg_wdata[r];
                end
            end
        end
    end

    // Any write attempt (suppressed or not) retires the producer; a reserve wins.
    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            sb_op[r] = SB_KEEP;
            for (int k = 0; k < NW; k++) begin
                if (we[k] && (wa[k*AW +: AW] == AW'(r))) begin
                    sb_op[r] = SB_CLEAR;
                end
            end
            if (rsv_en && (rsv_a == AW'(r))) begin
                sb_op[r] = SB_SET;
            end
            if (r == ZERO_REG) begin
                sb_op[r] = SB_KEEP;
            end
        end
    end

    always_comb begin
        busy_next = busy_reg;
        for (int r = 0; r < DEPTH; r++) begin
            case (sb_op[r])
                SB_SET:   busy_next[r] = 1'b1;
                SB_CLEAR: busy_next[r] = 1'b0;
                default:  busy_next[r] = busy_reg[r];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    for (genvar gi = 0; gi < NR; gi++) begin : g_read
        logic [AW-1:0] rsel;
        logic [W-1:0]  stored;

        assign rsel        = ra[gi*AW +: AW];
        assign stored      = regs_reg[rsel];
        assign rbusy[gi]   = busy_reg[rsel];

        if (BYPASS != 0) begin : g_bypass
            logic         byp_hit;
            logic [W-1:0] byp_data;

            gpr_wsel #(
                .W  (W),
                .AW (AW),
                .NW (NW)
            ) u_wsel (
                .we   (we),
                .wovf (wovf),
                .wa   (wa),
                .wd   (wd),
                .addr (rsel),
                .hit  (byp_hit),
                .data (byp_data)
            );

            assign rd[gi*W +: W] = byp_hit ? byp_data : stored;
        end else begin : g_direct
            assign rd[gi*W +: W] = stored;
        end
    end

    assign ovf_event = |(we & wovf);

    // A clear and an event in the same cycle leave exactly one event recorded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_flag_reg <= 1'b0;
            ovf_cnt_reg  <= '0;
        end else if (ovf_clr) begin
            ovf_flag_reg <= ovf_event;
            ovf_cnt_reg  <= ovf_event ? CW'(1) : '0;
        end else if (ovf_event) begin
            ovf_flag_reg <= 1'b1;
            if (ovf_cnt_reg != CNT_MAX) begin
                ovf_cnt_reg <= ovf_cnt_reg + CW'(1);
            end
        end
    end

    assign ovf_flag = ovf_flag_reg;
    assign ovf_cnt  = ovf_cnt_reg;

endmodule

// File: tb/tb_gpr_mp.sv
// Randomised and directed bench for gpr_mp against an array-based reference model.
// Each committed write is logged as one line.
module tb_gpr_mp;

    localparam int W      = 32;
    localparam int DEPTH  = 32;
    localparam int NR     = 2;
    localparam int NW     = 2;
    localparam int BYPASS = 1;
    localparam int CW     = 8;
    localparam int AW     = 5;
    localparam int CMAX   = 255;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR*AW-1:0] ra;
    logic [NR*W-1:0]  rd;
    logic [NR-1:0]    rbusy;
    logic [NW-1:0]    we;
    logic [NW*AW-1:0] wa;
    logic [NW*W-1:0]  wd;
    logic [NW-1:0]    wovf;
    logic             rsv_en;
    logic [AW-1:0]    rsv_a;
    logic             ovf_clr;
    logic             ovf_flag;
    logic [CW-1:0]    ovf_cnt;

    logic [AW-1:0] ra_v [NR];
    logic [AW-1:0] wa_v [NW];
    logic [W-1:0]  wd_v [NW];

    logic [W-1:0] m_reg  [DEPTH];
    bit           m_busy [DEPTH];
    bit           m_flag;
    int           m_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NR; gi++) begin : g_ra
        assign ra[gi*AW +: AW] = ra_v[gi];
    end
    for (genvar gi = 0; gi < NW; gi++) begin : g_wp
        assign wa[gi*AW +: AW] = wa_v[gi];
        assign wd[gi*W +: W]   = wd_v[gi];
    end

    gpr_mp #(
        .W      (W),
        .DEPTH  (DEPTH),
        .NR     (NR),
        .NW     (NW),
        .BYPASS (BYPASS),
        .CW     (CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra       (ra),
        .rd       (rd),
        .rbusy    (rbusy),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .wovf     (wovf),
        .rsv_en   (rsv_en),
        .rsv_a    (rsv_a),
        .ovf_clr  (ovf_clr),
        .ovf_flag (ovf_flag),
        .ovf_cnt  (ovf_cnt)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < DEPTH; r++) begin
            m_reg[r]  = '0;
            m_busy[r] = 1'b0;
        end
        m_flag = 1'b0;
        m_cnt  = 0;
    endtask

    function automatic logic [W-1:0] exp_rd(input int i);
        logic [W-1:0] v;
        v = m_reg[ra_v[i]];
        if (BYPASS != 0) begin
            for (int k = 0; k < NW; k++) begin
                if (we[k] && !wovf[k] && wa_v[k] != 0 && wa_v[k] == ra_v[i]) v = wd_v[k];
            end
        end
        return v;
    endfunction

    task automatic model_commit();
        bit ev;
        ev = 1'b0;
        for (int k = 0; k < NW; k++) begin
            if (we[k] && !wovf[k] && wa_v[k] != 0) begin
                m_reg[wa_v[k]] = wd_v[k];
                $display("Register[%2d]=%8x", wa_v[k], wd_v[k]);
            end
        end
        for (int k = 0; k < NW; k++) begin
            if (we[k] && wa_v[k] != 0) m_busy[wa_v[k]] = 1'b0;
            if (we[k] && wovf[k]) ev = 1'b1;
        end
        if (rsv_en && rsv_a != 0) m_busy[rsv_a] = 1'b1;
        if (ovf_clr) begin
            m_flag = 1'b0;
            m_cnt  = 0;
        end
        if (ev) begin
            m_flag = 1'b1;
            if (m_cnt < CMAX) m_cnt++;
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < NR; i++) begin
            check_eq($sformatf("%s rd%0d", tag, i), 64'(rd[i*W +: W]), 64'(exp_rd(i)));
            check_eq($sformatf("%s rbusy%0d", tag, i), 64'(rbusy[i]), 64'(m_busy[ra_v[i]]));
        end
        check_eq({tag, " ovf_flag"}, 64'(ovf_flag), 64'(m_flag));
        check_eq({tag, " ovf_cnt"}, 64'(ovf_cnt), 64'(m_cnt));
    endtask

    // Inputs are already applied; check combinational view, then clock and update model.
    task automatic step(input string tag);
        #2;
        check_all(tag);
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic idle();
        we      = '0;
        wovf    = '0;
        rsv_en  = 1'b0;
        rsv_a   = '0;
        ovf_clr = 1'b0;
        for (int k = 0; k < NW; k++) begin
            wa_v[k] = '0;
            wd_v[k] = '0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        for (int i = 0; i < NR; i++) ra_v[i] = '0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state over every address
        for (int a = 0; a < DEPTH; a++) begin
            ra_v[0] = AW'(a);
            ra_v[1] = AW'(DEPTH - 1 - a);
            #1;
            check_eq("reset rd0", 64'(rd[0 +: W]), 64'd0);
            check_eq("reset rd1", 64'(rd[W +: W]), 64'd0);
            check_eq("reset rbusy", 64'(rbusy), 64'd0);
        end
        check_eq("reset ovf_flag", 64'(ovf_flag), 64'd0);
        check_eq("reset ovf_cnt", 64'(ovf_cnt), 64'd0);

        // Register 0 ignores writes
        we = 2'b01; wa_v[0] = 5'd0; wd_v[0] = 32'hDEADBEEF; ra_v[0] = 5'd0;
        step("wr0");
        idle();
        #1 check_eq("reg0 after write", 64'(rd[0 +: W]), 64'd0);
        step("rd0");

        // Same-address conflict: port 1 wins
        we = 2'b11; wa_v[0] = 5'd5; wa_v[1] = 5'd5; wd_v[0] = 32'h11; wd_v[1] = 32'h22;
        step("conflict");
        idle(); ra_v[0] = 5'd5;
        #1 check_eq("conflict winner", 64'(rd[0 +: W]), 64'h22);
        step("conflict rd");

        // Bypass in the writing cycle
        we = 2'b01; wa_v[0] = 5'd7; wd_v[0] = 32'hA5A5A5A5; ra_v[0] = 5'd7;
        #1 check_eq("bypass same cycle", 64'(rd[0 +: W]), 64'hA5A5A5A5);
        step("bypass");
        idle();
        #1 check_eq("bypass after edge", 64'(rd[0 +: W]), 64'hA5A5A5A5);
        step("bypass rd");

        // Scoreboard set, clear, and set-wins
        rsv_en = 1'b1; rsv_a = 5'd9; ra_v[0] = 5'd9; ra_v[1] = 5'd0;
        step("rsv9");
        idle();
        #1 check_eq("busy after reserve", 64'(rbusy[0]), 64'd1);
        we = 2'b01; wa_v[0] = 5'd9; wd_v[0] = 32'h99;
        step("clr9");
        idle();
        #1 check_eq("busy after write", 64'(rbusy[0]), 64'd0);
        we = 2'b10; wa_v[1] = 5'd9; wd_v[1] = 32'h1234; rsv_en = 1'b1; rsv_a = 5'd9;
        step("rsv+wr9");
        idle();
        #1 check_eq("busy set wins", 64'(rbusy[0]), 64'd1);
        check_eq("data with reserve", 64'(rd[0 +: W]), 64'h1234);
        rsv_en = 1'b1; rsv_a = 5'd0;
        step("rsv0");
        idle();
        #1 check_eq("reg0 never busy", 64'(rbusy[1]), 64'd0);

        // Overflow write suppressed and counted; also retires a reservation
        we = 2'b01; wovf = 2'b01; wa_v[0] = 5'd9; wd_v[0] = 32'h55;
        step("ovf9");
        idle();
        #1 check_eq("ovf retires busy", 64'(rbusy[0]), 64'd0);
        check_eq("ovf suppressed data", 64'(rd[0 +: W]), 64'h1234);
        check_eq("ovf flag first", 64'(ovf_flag), 64'd1);
        check_eq("ovf cnt first", 64'(ovf_cnt), 64'd1);
        we = 2'b11; wovf = 2'b11; wa_v[0] = 5'd3; wa_v[1] = 5'd4;
        step("ovf two ports");
        idle();
        #1 check_eq("ovf cnt two ports", 64'(ovf_cnt), 64'd2);
        we = 2'b10; wovf = 2'b10; wa_v[1] = 5'd0;
        step("ovf addr0");
        idle();
        #1 check_eq("ovf cnt addr0", 64'(ovf_cnt), 64'd3);

        we = 2'b01; wovf = 2'b01; wa_v[0] = 5'd3; wd_v[0] = 32'h55;
        for (int n = 0; n < 300; n++) step("ovf sat");
        idle();
        #1 check_eq("ovf cnt saturated", 64'(ovf_cnt), 64'd255);
        ovf_clr = 1'b1; we = 2'b10; wovf = 2'b10; wa_v[1] = 5'd3;
        step("clr+event");
        idle();
        #1 check_eq("clr+event flag", 64'(ovf_flag), 64'd1);
        check_eq("clr+event cnt", 64'(ovf_cnt), 64'd1);
        ovf_clr = 1'b1;
        step("clr");
        idle();
        #1 check_eq("clr cnt", 64'(ovf_cnt), 64'd0);

        // Random traffic concentrated on a few addresses
        for (int n = 0; n < 500; n++) begin
            for (int k = 0; k < NW; k++) begin
                we[k]   = ($urandom_range(0, 1) == 1);
                wovf[k] = ($urandom_range(0, 7) == 0);
                wa_v[k] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 5));
                wd_v[k] = $urandom;
            end
            for (int i = 0; i < NR; i++) ra_v[i] = AW'($urandom_range(0, 7));
            rsv_en  = ($urandom_range(0, 2) == 0);
            rsv_a   = AW'($urandom_range(0, 7));
            ovf_clr = ($urandom_range(0, 15) == 0);
            step("rand");
        end

        // Asynchronous reset between edges
        idle();
        we = 2'b11; wa_v[0] = 5'd12; wd_v[0] = 32'hCAFE0001; wa_v[1] = 5'd13; wd_v[1] = 32'hCAFE0002;
        rsv_en = 1'b1; rsv_a = 5'd14;
        step("pre-reset wr");
        idle();
        we = 2'b01; wovf = 2'b01; wa_v[0] = 5'd15;
        step("pre-reset ovf");
        idle();
        ra_v[0] = 5'd12; ra_v[1] = 5'd14;
        #1 check_eq("pre-reset rd0", 64'(rd[0 +: W]), 64'hCAFE0001);
        check_eq("pre-reset rbusy1", 64'(rbusy[1]), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("async rst rd0", 64'(rd[0 +: W]), 64'd0);
        check_eq("async rst rbusy", 64'(rbusy), 64'd0);
        check_eq("async rst ovf_flag", 64'(ovf_flag), 64'd0);
        check_eq("async rst ovf_cnt", 64'(ovf_cnt), 64'd0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        ra_v[0] = 5'd13;
        step("post-reset");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
